// File: rtl/iq_pkg.sv
// Shared widths and entry layout for the in-order issue queue.
package iq_pkg;
  localparam int PHYS_REG_W = 6;
  localparam int FLAGS_W = 23;
  localparam int FLAG_REGWRITE_BIT = 20;

  typedef struct packed {
    logic [31:0]           UID;
    logic [31:0]           Instr;
    logic [31:0]           PC;
    logic [31:0]           PC_Plus4;
    logic [FLAGS_W-1:0]    Flags;
    logic [PHYS_REG_W-1:0] rs;
    logic [PHYS_REG_W-1:0] rt;
    logic [PHYS_REG_W-1:0] rd;
  } iq_entry_t;
endpackage

// File: rtl/issue_queue_phys_busy_table.sv
// Physical-register busy bits with two readiness ports.
// IQ_WAKEUP_BYPASS_EN lets a same-cycle writeback count as ready.
module phys_busy_table
  import iq_pkg::*;
#(
  parameter int NUM_PHYS_REGS = 64
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  clear_all,
  input  logic                  set_en,
  input  logic [PHYS_REG_W-1:0] set_reg,
  input  logic                  clr_en,
  input  logic [PHYS_REG_W-1:0] clr_reg,
  input  logic [PHYS_REG_W-1:0] rd_a,
  input  logic [PHYS_REG_W-1:0] rd_b,
  output logic                  ready_a,
  output logic                  ready_b
);
  logic [NUM_PHYS_REGS-1:0] busy;
  logic                     byp_a;
  logic                     byp_b;

  // set is written last so a new producer beats a same-cycle wakeup
  always_ff @(posedge CLK) begin
    if (RESET || clear_all) begin
      busy <= '0;
    end else begin
      if (clr_en && clr_reg != '0)
        busy[clr_reg] <= 1'b0;
      if (set_en && set_reg != '0)
        busy[set_reg] <= 1'b1;
    end
  end

`ifdef IQ_WAKEUP_BYPASS_EN
  assign byp_a = clr_en && (clr_reg == rd_a);
  assign byp_b = clr_en && (clr_reg == rd_b);
`else
  assign byp_a = 1'b0;
  assign byp_b = 1'b0;
`endif

  assign ready_a = (rd_a == '0) || !busy[rd_a] || byp_a;
  assign ready_b = (rd_b == '0) || !busy[rd_b] || byp_b;
endmodule

// File: rtl/issue_queue.sv
// In-order issue queue: circular FIFO gated by a busy table.
// Optional IQ_WAKEUP_BYPASS_EN issues the head in its wakeup cycle.
module issue_queue
  import iq_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int NUM_PHYS_REGS = 64
) (
  input  logic                        CLK,
  input  logic                        RESET,
  input  logic                        enq_valid,
  output logic                        enq_ready,
  input  logic [31:0]                 enq_UID,
  input  logic [31:0]                 enq_Instr,
  input  logic [31:0]                 enq_PC,
  input  logic [31:0]                 enq_PC_Plus4,
  input  logic [FLAGS_W-1:0]          enq_Flags,
  input  logic [PHYS_REG_W-1:0]       enq_rs,
  input  logic [PHYS_REG_W-1:0]       enq_rt,
  input  logic [PHYS_REG_W-1:0]       enq_rd,
  input  logic                        flush,
  input  logic                        RegWrite_fMM,
  input  logic [PHYS_REG_W-1:0]       WriteRegister_fMM,
  output logic [31:0]                 Instr_UID_out,
  output logic [31:0]                 Instr_out,
  output logic [31:0]                 Instr_PC_out,
  output logic [31:0]                 Instr_PC_Plus4_out,
  output logic [FLAGS_W-1:0]          Instr_Flags_out,
  output logic [PHYS_REG_W-1:0]       rs_out,
  output logic [PHYS_REG_W-1:0]       rt_out,
  output logic [PHYS_REG_W-1:0]       rd_out,
  output logic                        iq_empty,
  output logic [$clog2(DEPTH):0]      count
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  iq_entry_t        mem [DEPTH];
  iq_entry_t        hd;
  iq_entry_t        new_e;
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic             do_enq;
  logic             issue;
  logic             ready_a;
  logic             ready_b;

  assign new_e = '{
    UID:      enq_UID,
    Instr:    enq_Instr,
    PC:       enq_PC,
    PC_Plus4: enq_PC_Plus4,
    Flags:    enq_Flags,
    rs:       enq_rs,
    rt:       enq_rt,
    rd:       enq_rd
  };

  assign hd = mem[head];
  assign Instr_UID_out      = hd.UID;
  assign Instr_out          = hd.Instr;
  assign Instr_PC_out       = hd.PC;
  assign Instr_PC_Plus4_out = hd.PC_Plus4;
  assign Instr_Flags_out    = hd.Flags;
  assign rs_out             = hd.rs;
  assign rt_out             = hd.rt;
  assign rd_out             = hd.rd;

  // full refuses enqueue even when the head leaves this cycle
  assign enq_ready = (count != CNT_W'(DEPTH));
  assign do_enq    = enq_valid && enq_ready;
  assign issue     = (count != '0) && ready_a && ready_b;
  assign iq_empty  = !issue;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++)
        mem[i] <= '0;
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (do_enq) begin
        mem[tail] <= new_e;
        tail      <= tail + 1'b1;
      end
      if (issue)
        head <= head + 1'b1;
      unique case ({do_enq, issue})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  phys_busy_table #(
    .NUM_PHYS_REGS(NUM_PHYS_REGS)
  ) u_busy (
    .CLK       (CLK),
    .RESET     (RESET),
    .clear_all (flush),
    .set_en    (do_enq && enq_Flags[FLAG_REGWRITE_BIT]),
    .set_reg   (enq_rd),
    .clr_en    (RegWrite_fMM),
    .clr_reg   (WriteRegister_fMM),
    .rd_a      (hd.rs),
    .rd_b      (hd.rt),
    .ready_a   (ready_a),
    .ready_b   (ready_b)
  );
endmodule

// File: tb/tb_issue_queue.sv
// Bench for issue_queue: vector table, corner sequences, random vs model.
module tb_issue_queue;
  import iq_pkg::*;

  localparam int DEPTH = 8;
`ifdef IQ_WAKEUP_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        CLK = 1'b0;
  logic        RESET;
  logic        enq_valid;
  logic        enq_ready;
  logic [31:0] enq_UID;
  logic [31:0] enq_Instr;
  logic [31:0] enq_PC;
  logic [31:0] enq_PC_Plus4;
  logic [22:0] enq_Flags;
  logic [5:0]  enq_rs;
  logic [5:0]  enq_rt;
  logic [5:0]  enq_rd;
  logic        flush;
  logic        RegWrite_fMM;
  logic [5:0]  WriteRegister_fMM;
  logic [31:0] Instr_UID_out;
  logic [31:0] Instr_out;
  logic [31:0] Instr_PC_out;
  logic [31:0] Instr_PC_Plus4_out;
  logic [22:0] Instr_Flags_out;
  logic [5:0]  rs_out;
  logic [5:0]  rt_out;
  logic [5:0]  rd_out;
  logic        iq_empty;
  logic [3:0]  count;

  issue_queue #(.DEPTH(DEPTH), .NUM_PHYS_REGS(64)) dut (
    .CLK(CLK), .RESET(RESET),
    .enq_valid(enq_valid), .enq_ready(enq_ready),
    .enq_UID(enq_UID), .enq_Instr(enq_Instr),
    .enq_PC(enq_PC), .enq_PC_Plus4(enq_PC_Plus4),
    .enq_Flags(enq_Flags),
    .enq_rs(enq_rs), .enq_rt(enq_rt), .enq_rd(enq_rd),
    .flush(flush),
    .RegWrite_fMM(RegWrite_fMM),
    .WriteRegister_fMM(WriteRegister_fMM),
    .Instr_UID_out(Instr_UID_out), .Instr_out(Instr_out),
    .Instr_PC_out(Instr_PC_out),
    .Instr_PC_Plus4_out(Instr_PC_Plus4_out),
    .Instr_Flags_out(Instr_Flags_out),
    .rs_out(rs_out), .rt_out(rt_out), .rd_out(rd_out),
    .iq_empty(iq_empty), .count(count)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    bit          rst;
    bit          ev;
    logic [31:0] uid;
    logic [5:0]  rs;
    logic [5:0]  rt;
    logic [5:0]  rd;
    bit          rw;
    bit          fl;
    bit          wb;
    logic [5:0]  wbr;
  } stim_t;

  typedef struct {
    stim_t       s;
    bit          e_empty;
    int          e_cnt;
    bit          chk_uid;
    logic [31:0] e_uid;
  } vec_t;

  int          vectors = 0;
  int          miscompares = 0;
  iq_entry_t   mq[$];
  bit [63:0]   mbusy;
  logic [31:0] issued[$];
  vec_t        tbl[11];

  function automatic stim_t idle();
    stim_t s;
    s.rst = 0; s.ev = 0; s.uid = 0;
    s.rs = 0; s.rt = 0; s.rd = 0;
    s.rw = 0; s.fl = 0; s.wb = 0; s.wbr = 0;
    return s;
  endfunction

  function automatic stim_t enq(input int u, input int a,
                                input int b, input int d,
                                input bit w);
    stim_t s = idle();
    s.ev = 1; s.uid = 32'(u);
    s.rs = 6'(a); s.rt = 6'(b); s.rd = 6'(d); s.rw = w;
    return s;
  endfunction

  function automatic stim_t wake(input int r);
    stim_t s = idle();
    s.wb = 1; s.wbr = 6'(r);
    return s;
  endfunction

  function automatic vec_t v(input stim_t s, input bit e,
                             input int c, input bit ch,
                             input int u);
    vec_t x;
    x.s = s; x.e_empty = e; x.e_cnt = c;
    x.chk_uid = ch; x.e_uid = 32'(u);
    return x;
  endfunction

  function automatic iq_entry_t mk(input stim_t s);
    iq_entry_t e;
    e.UID      = s.uid;
    e.Instr    = s.uid ^ 32'hdeadbeef;
    e.PC       = {s.uid[29:0], 2'b00};
    e.PC_Plus4 = e.PC + 32'd4;
    e.Flags    = s.uid[22:0] ^ 23'h15a5a5;
    e.Flags[FLAG_REGWRITE_BIT] = s.rw;
    e.rs = s.rs; e.rt = s.rt; e.rd = s.rd;
    return e;
  endfunction

  function automatic bit mready(input logic [5:0] r,
                                input stim_t s);
    return (r == 0) || !mbusy[r] || (BYP && s.wb && s.wbr == r);
  endfunction

  task automatic check(input string n, input logic [31:0] act,
                       input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h @%0t",
               n, act, exp, $time);
    end
  endtask

  task automatic drive(input stim_t s);
    iq_entry_t e = mk(s);
    RESET = s.rst; enq_valid = s.ev;
    enq_UID = e.UID; enq_Instr = e.Instr;
    enq_PC = e.PC; enq_PC_Plus4 = e.PC_Plus4;
    enq_Flags = e.Flags;
    enq_rs = e.rs; enq_rt = e.rt; enq_rd = e.rd;
    flush = s.fl; RegWrite_fMM = s.wb;
    WriteRegister_fMM = s.wbr;
  endtask

  // one clock: compare against the model, then advance the model
  task automatic cycle(input stim_t s);
    int sz;
    bit ei;
    bit full;
    drive(s);
    #1;
    sz = mq.size();
    ei = (sz > 0) && mready(mq[0].rs, s) && mready(mq[0].rt, s);
    check("count", 32'(count), 32'(sz));
    check("enq_ready", 32'(enq_ready), 32'(sz != DEPTH));
    check("iq_empty", 32'(iq_empty), 32'(!ei));
    if (sz > 0) begin
      check("head_uid", Instr_UID_out, mq[0].UID);
      check("head_instr", Instr_out, mq[0].Instr);
      check("head_pc", Instr_PC_out, mq[0].PC);
      check("head_pc4", Instr_PC_Plus4_out, mq[0].PC_Plus4);
      check("head_flags", 32'(Instr_Flags_out), 32'(mq[0].Flags));
      check("head_regs", 32'({rs_out, rt_out, rd_out}),
            32'({mq[0].rs, mq[0].rt, mq[0].rd}));
    end
    if (!iq_empty) issued.push_back(Instr_UID_out);
    @(posedge CLK);
    if (s.rst || s.fl) begin
      mq.delete();
      mbusy = '0;
    end else begin
      full = (sz == DEPTH);
      if (ei) void'(mq.pop_front());
      if (s.ev && !full) mq.push_back(mk(s));
      if (s.wb && s.wbr != 0) mbusy[s.wbr] = 1'b0;
      if (s.ev && !full && s.rw && s.rd != 0) mbusy[s.rd] = 1'b1;
    end
    @(negedge CLK);
  endtask

  initial begin
    stim_t s;
    drive(idle());
    RESET = 1'b1;
    mbusy = '0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    RESET = 1'b0;
    #1;
    check("rst_instr", Instr_out, 0);
    check("rst_pc", Instr_PC_out, 0);
    check("rst_flags", 32'(Instr_Flags_out), 0);
    check("rst_rd", 32'(rd_out), 0);

    tbl[0]  = v(idle(), 1, 0, 1, 0);
    tbl[1]  = v(enq(1, 0, 0, 5, 1), 1, 0, 0, 0);
    tbl[2]  = v(idle(), 0, 1, 1, 1);
    tbl[3]  = v(idle(), 1, 0, 0, 0);
    tbl[4]  = v(enq(2, 0, 0, 7, 1), 1, 0, 0, 0);
    tbl[5]  = v(enq(3, 7, 0, 8, 0), 0, 1, 1, 2);
    tbl[6]  = v(idle(), 1, 1, 1, 3);
    tbl[7]  = v(idle(), 1, 1, 1, 3);
    tbl[8]  = v(wake(7), !BYP, 1, 1, 3);
    tbl[9]  = v(idle(), BYP, BYP ? 0 : 1, !BYP, 3);
    tbl[10] = v(idle(), 1, 0, 0, 0);
    for (int i = 0; i < 11; i++) begin
      drive(tbl[i].s);
      #1;
      check($sformatf("tbl%0d_empty", i), 32'(iq_empty),
            32'(tbl[i].e_empty));
      check($sformatf("tbl%0d_count", i), 32'(count),
            32'(tbl[i].e_cnt));
      if (tbl[i].chk_uid)
        check($sformatf("tbl%0d_uid", i), Instr_UID_out,
              tbl[i].e_uid);
      cycle(tbl[i].s);
    end

    // fill behind busy r5, refuse overflow, then wake and drain
    issued.delete();
    for (int i = 0; i < 8; i++) cycle(enq(10 + i, 5, 0, 0, 0));
    check("full_count", 32'(count), 8);
    check("full_ready", 32'(enq_ready), 0);
    cycle(enq(18, 5, 0, 0, 0));
    check("ovf_count", 32'(count), 8);
    s = enq(19, 5, 0, 0, 0);
    s.wb = 1; s.wbr = 5;
    cycle(s);
    cycle(enq(19, 5, 0, 0, 0));
    check("full_issue_count", 32'(count), 7);
    for (int i = 0; i < 12; i++) cycle(idle());
    check("drain_count", 32'(count), 0);
    check("drain_n", 32'(issued.size()), BYP ? 9 : 8);
    for (int k = 0; k < 8 && k < issued.size(); k++)
      check($sformatf("drain_uid%0d", k), issued[k], 32'(10 + k));

    // back-to-back stream through wrapping pointers
    issued.delete();
    for (int i = 0; i < 20; i++) cycle(enq(100 + i, 0, 0, 0, 0));
    for (int i = 0; i < 3; i++) cycle(idle());
    check("stream_n", 32'(issued.size()), 20);
    for (int k = 0; k < 20 && k < issued.size(); k++)
      check($sformatf("stream_uid%0d", k), issued[k], 32'(100 + k));

    // flush with concurrent enqueue and writeback
    cycle(enq(199, 0, 0, 10, 1));
    cycle(enq(200, 0, 0, 9, 1));
    for (int i = 0; i < 4; i++) cycle(enq(201 + i, 9, 10, 0, 0));
    check("pre_flush_count", 32'(count), 4);
    s = enq(299, 0, 0, 0, 0);
    s.fl = 1; s.wb = 1; s.wbr = 9;
    cycle(s);
    check("flush_count", 32'(count), 0);
    check("flush_empty", 32'(iq_empty), 1);
    cycle(enq(300, 9, 10, 0, 0));
    check("post_flush_issue", 32'(iq_empty), 0);
    check("post_flush_uid", Instr_UID_out, 300);
    cycle(idle());

    for (int i = 0; i < 400; i++) begin
      s = idle();
      s.rst = ($urandom_range(0, 199) == 0);
      s.ev  = ($urandom_range(0, 1) == 1);
      s.uid = 32'(1000 + i);
      s.rs  = 6'($urandom_range(0, 7));
      s.rt  = 6'($urandom_range(0, 7));
      s.rd  = 6'($urandom_range(0, 7));
      s.rw  = ($urandom_range(0, 1) == 1);
      s.fl  = ($urandom_range(0, 39) == 0);
      s.wb  = ($urandom_range(0, 2) == 0);
      s.wbr = 6'($urandom_range(0, 7));
      cycle(s);
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/issue_queue.md
Name: issue_queue

Overview:
- In-order issue queue between rename/dispatch and the register-read stage.
- Buffers renamed instructions in a circular FIFO.
- Tracks a per-physical-register busy table.
- Presents the head entry to register-read only when its source physical registers are ready; that stage consumes the head every cycle iq_empty is low.

Parameters:
DEPTH, 8, number of queue entries (power of two, >=2)
NUM_PHYS_REGS, 64, physical registers tracked in busy table (register indices are 6 bits)

Ports:
CLK  input  1  clock
RESET  input  1  synchronous, active-high reset
enq_valid  input  1  dispatch presents an instruction
enq_ready  output  1  queue can accept (not full)
enq_UID  input  32  instruction unique ID
enq_Instr  input  32  raw instruction word
enq_PC  input  32  instruction PC
enq_PC_Plus4  input  32  PC+4
enq_Flags  input  23  decoded flags; bit 20 = RegWrite
enq_rs  input  6  physical source A
enq_rt  input  6  physical source B
enq_rd  input  6  physical destination
flush  input  1  squash all queued entries
RegWrite_fMM  input  1  writeback valid
WriteRegister_fMM  input  6  writeback physical register
Instr_UID_out  output  32  head UID
Instr_out  output  32  head instruction
Instr_PC_out  output  32  head PC
Instr_PC_Plus4_out  output  32  head PC+4
Instr_Flags_out  output  23  head flags
rs_out  output  6  head rs
rt_out  output  6  head rt
rd_out  output  6  head rd
iq_empty  output  1  low = head valid and ready; head issues this cycle
count  output  $clog2(DEPTH)+1  occupied entries

Behaviour:
- Clocking: single clock CLK; synchronous active-high RESET.
- Reset effects:
  - head/tail pointers and count = 0; all entries invalid.
  - Busy table all clear.
  - iq_empty = 1, enq_ready = 1.
  - Head data outputs read 0 (entry storage cleared).
- Storage and pointers:
  - Circular buffer with head/tail pointers of $clog2(DEPTH) bits; they wrap naturally modulo DEPTH.
  - count tracks occupancy 0..DEPTH.
- Enqueue: enq_valid && enq_ready at posedge writes the entry at tail, tail+1, count+1.
- enq_ready = (count != DEPTH).
  - Full blocks enqueue even if a dequeue occurs the same cycle (no same-cycle slot reuse).
- No fall-through: an entry enqueued into an empty queue is visible at the head one cycle later at earliest.
- Head outputs are combinational from the head entry storage; register-read stage registers them.
- Source readiness: src_ready(r) = (r == 0) || !busy[r] || (bypass term, see Optional Feature).
- Issue: issue = (count != 0) && src_ready(rs_head) && src_ready(rt_head).
  - iq_empty = !issue.
  - On issue: head+1, count-1 at posedge. No stall input; issue implies consumption.
- Simultaneous enqueue and issue: count unchanged, both pointers advance.
- Busy table:
  - On enqueue with enq_Flags[20] = 1 and enq_rd != 0: busy[enq_rd] <= 1.
  - On RegWrite_fMM with WriteRegister_fMM != 0: busy[WriteRegister_fMM] <= 0.
  - Same register set and cleared in the same cycle: set wins (new producer).
  - Register 0 is never busy.
- Strict in-order issue: a non-ready head blocks younger entries.
- Flush:
  - At posedge: pointers and count = 0, all entries invalid, busy table cleared.
  - Overrides enqueue and issue in that cycle; enq_ready stays per pre-flush count that cycle.
  - Wakeups in the flush cycle are discarded.
- Priority: RESET > flush > normal operation.

Optional Feature:
- Macro: IQ_WAKEUP_BYPASS_EN
- Defined: src_ready also true when RegWrite_fMM && WriteRegister_fMM == r in the same cycle; the head issues in the writeback cycle.
- Undefined: the head issues no earlier than the cycle after the busy bit clears (one extra bubble per dependence).

Decomposition:
- Package iq_pkg: PHYS_REG_W = 6, FLAGS_W = 23, FLAG_REGWRITE_BIT = 20, and a packed struct iq_entry_t {UID, Instr, PC, PC_Plus4, Flags, rs, rt, rd}.
- Sub-module phys_busy_table: NUM_PHYS_REGS set/clear bit vector with two read ports plus bypass compare; instantiated once.

Test Plan:
- Reset then enqueue UID=1, rs=0, rt=0, rd=5, Flags[20]=1 → iq_empty=0 one cycle later, Instr_UID_out=1; next cycle iq_empty=1, count=0.
- Enqueue UID=2 writing rd=7, then UID=3 with rs=7 → UID=2 issues; UID=3 held (iq_empty=1) until RegWrite_fMM=1, WriteRegister_fMM=7; it issues that cycle with bypass, one cycle later without.
- Enqueue 8 entries whose rs is busy → count=8, enq_ready=0; a 9th enq_valid is ignored; wake → entries drain in UID order, enq_ready=1 after first issue.
- Full queue, head issuing, enq_valid=1 same cycle → enqueue refused, count=7.
- Enqueue/issue 20 instructions continuously → pointers wrap, UIDs out in order 1..20, no loss.
- Four queued entries, flush=1 with simultaneous enq_valid and writeback → next cycle count=0, iq_empty=1, busy table all clear, enqueued entry dropped.
